// File: rtl/misc_issue_queue_pkg.sv
// Shared types for the misc issue queue: pipe op bundle, queue entry, sizing.
// Instruction classes decide whether an op must wait to become the ROB head.
package misc_issue_queue_pkg;

    localparam int MISC_IQ_DEPTH = 4;
    localparam int WB_PORTS      = 4;
    localparam int PREG_W        = 6;
    localparam int ROB_W         = 6;

    typedef enum logic [1:0] {
        ALU_INST  = 2'd0,
        BR_INST   = 2'd1,
        PRIV_INST = 2'd2,
        MEM_INST  = 2'd3
    } InstType;

    typedef struct packed {
        logic              valid;
        InstType           inst_type;
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] pdest;
        logic [31:0]       src0;
        logic [31:0]       src1;
    } ExeBaseSt;

    typedef struct packed {
        ExeBaseSt    base;
        logic [3:0]  misc_op;
        logic [31:0] imm;
        logic [31:0] pc;
    } MiscExeSt;

    typedef struct packed {
        MiscExeSt          exe;
        logic [PREG_W-1:0] psrc0;
        logic [PREG_W-1:0] psrc1;
        logic              src0_rdy;
        logic              src1_rdy;
    } MiscIqSt;

    function automatic logic rob_gate_ok(input MiscIqSt e, input logic [ROB_W-1:0] rob_head);
        return (e.exe.base.inst_type != PRIV_INST) || (e.exe.base.rob_idx == rob_head);
    endfunction

endpackage

// File: rtl/misc_iq_wakeup.sv
// Compares one entry's two source tags against every wakeup port.
// Physical register 0 is hardwired ready.
module misc_iq_wakeup
    import misc_issue_queue_pkg::*;
(
    input  logic [PREG_W-1:0]               psrc0_i,
    input  logic [PREG_W-1:0]               psrc1_i,
    input  logic                            rdy0_i,
    input  logic                            rdy1_i,
    input  logic [WB_PORTS-1:0]             wb_valid_i,
    input  logic [WB_PORTS-1:0][PREG_W-1:0] wb_pdest_i,
    output logic                            rdy0_o,
    output logic                            rdy1_o
);

    logic hit0;
    logic hit1;

    always_comb begin
        hit0 = (psrc0_i == '0);
        hit1 = (psrc1_i == '0);
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid_i[p] && wb_pdest_i[p] == psrc0_i) hit0 = 1'b1;
            if (wb_valid_i[p] && wb_pdest_i[p] == psrc1_i) hit1 = 1'b1;
        end
    end

    assign rdy0_o = rdy0_i | hit0;
    assign rdy1_o = rdy1_i | hit1;

endmodule

// File: rtl/misc_issue_queue.sv
// In-order issue queue for the misc pipe with a single issue register.
// Priv ops additionally wait until they reach the ROB head.
module misc_issue_queue
    import misc_issue_queue_pkg::*;
#(
    parameter int DEPTH = MISC_IQ_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            disp_valid_i,
    input  MiscIqSt                         disp_i,
    output logic                            disp_ready_o,
    input  logic [WB_PORTS-1:0]             wb_valid_i,
    input  logic [WB_PORTS-1:0][PREG_W-1:0] wb_pdest_i,
    input  logic [ROB_W-1:0]                rob_head_i,
    output logic [PREG_W-1:0]               rf_raddr0_o,
    output logic [PREG_W-1:0]               rf_raddr1_o,
    input  logic [31:0]                     rf_rdata0_i,
    input  logic [31:0]                     rf_rdata1_i,
    output MiscExeSt                        exe_o,
    input  logic                            exe_ready_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    MiscIqSt           ent_q [DEPTH];
    MiscIqSt           ent_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    MiscExeSt          iss_q, iss_d;
    logic [PREG_W-1:0] ps0_q, ps0_d;
    logic [PREG_W-1:0] ps1_q, ps1_d;

    logic [DEPTH-1:0]  rdy0_nxt, rdy1_nxt;
    logic              disp_rdy0, disp_rdy1;
    MiscIqSt           head_ent;
    logic              issue_free, do_issue, do_disp;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wk
        misc_iq_wakeup u_wk (
            .psrc0_i    (ent_q[i].psrc0),
            .psrc1_i    (ent_q[i].psrc1),
            .rdy0_i     (ent_q[i].src0_rdy),
            .rdy1_i     (ent_q[i].src1_rdy),
            .wb_valid_i (wb_valid_i),
            .wb_pdest_i (wb_pdest_i),
            .rdy0_o     (rdy0_nxt[i]),
            .rdy1_o     (rdy1_nxt[i])
        );
    end

    misc_iq_wakeup u_wk_disp (
        .psrc0_i    (disp_i.psrc0),
        .psrc1_i    (disp_i.psrc1),
        .rdy0_i     (disp_i.src0_rdy),
        .rdy1_i     (disp_i.src1_rdy),
        .wb_valid_i (wb_valid_i),
        .wb_pdest_i (wb_pdest_i),
        .rdy0_o     (disp_rdy0),
        .rdy1_o     (disp_rdy1)
    );

    assign head_ent     = ent_q[head_q];
    assign disp_ready_o = (cnt_q != FULL);
    assign issue_free   = ~iss_q.base.valid | exe_ready_i;
    assign do_disp      = disp_valid_i & disp_ready_o;
    // Issue looks only at registered ready bits; no wakeup bypass.
    assign do_issue     = vld_q[head_q] & head_ent.src0_rdy & head_ent.src1_rdy
                        & rob_gate_ok(head_ent, rob_head_i) & issue_free;

    always_comb begin
        ent_d  = ent_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        iss_d  = iss_q;
        ps0_d  = ps0_q;
        ps1_d  = ps1_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].src0_rdy = rdy0_nxt[i];
            ent_d[i].src1_rdy = rdy1_nxt[i];
        end
        if (issue_free) iss_d = '0;
        if (do_issue) begin
            iss_d            = head_ent.exe;
            iss_d.base.valid = 1'b1;
            ps0_d            = head_ent.psrc0;
            ps1_d            = head_ent.psrc1;
            vld_d[head_q]    = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (do_disp) begin
            ent_d[tail_q]          = disp_i;
            ent_d[tail_q].src0_rdy = disp_rdy0;
            ent_d[tail_q].src1_rdy = disp_rdy1;
            vld_d[tail_q]          = 1'b1;
            tail_d                 = tail_q + 1'b1;
        end
        cnt_d = cnt_q + (PTR_W+1)'(do_disp) - (PTR_W+1)'(do_issue);
        if (flush_i) begin
            vld_d  = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            iss_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            iss_q  <= '0;
            ps0_q  <= '0;
            ps1_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            iss_q  <= iss_d;
            ps0_q  <= ps0_d;
            ps1_q  <= ps1_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign rf_raddr0_o = ps0_q;
    assign rf_raddr1_o = ps1_q;

    always_comb begin
        exe_o = '0;
        if (iss_q.base.valid) begin
            exe_o           = iss_q;
            exe_o.base.src0 = rf_rdata0_i;
            exe_o.base.src1 = rf_rdata1_i;
        end
    end

endmodule

// File: tb/tb_misc_issue_queue.sv
// Directed bench for misc_issue_queue with a simple regfile model.
// Expected values are hand-traced cycle by cycle.
module tb_misc_issue_queue;
    import misc_issue_queue_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            flush_i;
    logic                            disp_valid_i;
    MiscIqSt                         disp_i;
    logic                            disp_ready_o;
    logic [WB_PORTS-1:0]             wb_valid_i;
    logic [WB_PORTS-1:0][PREG_W-1:0] wb_pdest_i;
    logic [ROB_W-1:0]                rob_head_i;
    logic [PREG_W-1:0]               rf_raddr0_o;
    logic [PREG_W-1:0]               rf_raddr1_o;
    logic [31:0]                     rf_rdata0_i;
    logic [31:0]                     rf_rdata1_i;
    MiscExeSt                        exe_o;
    logic                            exe_ready_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_rdata0_i = 32'h1000 + {26'h0, rf_raddr0_o};
    assign rf_rdata1_i = 32'h1000 + {26'h0, rf_raddr1_o};

    misc_issue_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .disp_valid_i (disp_valid_i),
        .disp_i       (disp_i),
        .disp_ready_o (disp_ready_o),
        .wb_valid_i   (wb_valid_i),
        .wb_pdest_i   (wb_pdest_i),
        .rob_head_i   (rob_head_i),
        .rf_raddr0_o  (rf_raddr0_o),
        .rf_raddr1_o  (rf_raddr1_o),
        .rf_rdata0_i  (rf_rdata0_i),
        .rf_rdata1_i  (rf_rdata1_i),
        .exe_o        (exe_o),
        .exe_ready_i  (exe_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic MiscIqSt mk_op(input int rob, input InstType t,
                                      input int ps0, input int ps1,
                                      input bit r0, input bit r1);
        MiscIqSt o;
        o = '0;
        o.exe.base.inst_type = t;
        o.exe.base.rob_idx   = ROB_W'(rob);
        o.exe.base.pdest     = PREG_W'(rob + 1);
        o.exe.pc             = 32'(rob * 4);
        o.psrc0              = PREG_W'(ps0);
        o.psrc1              = PREG_W'(ps1);
        o.src0_rdy           = r0;
        o.src1_rdy           = r1;
        return o;
    endfunction

    task automatic chk_issue(input string tag, input int rob);
        chk({tag, "_vld"}, 64'(exe_o.base.valid), 64'd1);
        chk({tag, "_rob"}, 64'(exe_o.base.rob_idx), 64'(rob));
    endtask

    initial begin
        rst          = 1'b1;
        flush_i      = 1'b0;
        disp_valid_i = 1'b0;
        disp_i       = '0;
        wb_valid_i   = '0;
        wb_pdest_i   = '0;
        rob_head_i   = '0;
        exe_ready_i  = 1'b1;
        tick();
        tick();
        chk("rst_vld", 64'(exe_o.base.valid), 64'd0);
        chk("rst_exe", 64'(exe_o), 64'd0);
        chk("rst_rdy", 64'(disp_ready_o), 64'd1);
        rst = 1'b0;
        tick();

        // 1: late wakeup of src0
        disp_valid_i = 1'b1;
        disp_i = mk_op(1, BR_INST, 5, 0, 1'b0, 1'b0);
        tick();
        disp_valid_i = 1'b0;
        chk("t1_c1", 64'(exe_o.base.valid), 64'd0);
        tick();
        chk("t1_c2", 64'(exe_o.base.valid), 64'd0);
        tick();
        wb_valid_i = 4'b0001;
        wb_pdest_i[0] = 6'd5;
        tick();
        wb_valid_i = '0;
        chk("t1_c4", 64'(exe_o.base.valid), 64'd0);
        tick();
        chk_issue("t1_c5", 1);
        chk("t1_raddr0", 64'(rf_raddr0_o), 64'd5);
        chk("t1_src0", 64'(exe_o.base.src0), 64'h1005);
        chk("t1_src1", 64'(exe_o.base.src1), 64'h1000);
        tick();
        chk("t1_c6", 64'(exe_o.base.valid), 64'd0);

        // 2: fill under backpressure, then drain in order
        exe_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_rdy%0d", k), 64'(disp_ready_o), 64'd1);
            disp_valid_i = 1'b1;
            disp_i = mk_op(k, ALU_INST, 0, 0, 1'b1, 1'b1);
            tick();
        end
        disp_valid_i = 1'b0;
        chk("t2_full", 64'(disp_ready_o), 64'd0);
        chk_issue("t2_hold", 0);
        exe_ready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk_issue($sformatf("t2_drain%0d", k), k);
        end
        chk("t2_rdy_after", 64'(disp_ready_o), 64'd1);
        tick();
        chk("t2_empty", 64'(exe_o.base.valid), 64'd0);

        // 3: priv op waits for ROB head, younger branch waits behind it
        rob_head_i = 6'd6;
        disp_valid_i = 1'b1;
        disp_i = mk_op(7, PRIV_INST, 0, 0, 1'b1, 1'b1);
        tick();
        disp_i = mk_op(8, BR_INST, 0, 0, 1'b1, 1'b1);
        tick();
        disp_valid_i = 1'b0;
        chk("t3_blk0", 64'(exe_o.base.valid), 64'd0);
        tick();
        chk("t3_blk1", 64'(exe_o.base.valid), 64'd0);
        rob_head_i = 6'd7;
        tick();
        chk_issue("t3_priv", 7);
        chk("t3_type", 64'(exe_o.base.inst_type), 64'(PRIV_INST));
        tick();
        chk_issue("t3_br", 8);
        rob_head_i = '0;
        tick();

        // 4: same-cycle wakeup during dispatch
        disp_valid_i = 1'b1;
        disp_i = mk_op(20, BR_INST, 0, 9, 1'b0, 1'b0);
        wb_valid_i = 4'b0100;
        wb_pdest_i[2] = 6'd9;
        tick();
        disp_valid_i = 1'b0;
        wb_valid_i = '0;
        chk("t4_c1", 64'(exe_o.base.valid), 64'd0);
        tick();
        chk_issue("t4_iss", 20);
        chk("t4_raddr1", 64'(rf_raddr1_o), 64'd9);
        chk("t4_src1", 64'(exe_o.base.src1), 64'h1009);
        tick();

        // 5: flush with queued ops and a valid issue register
        exe_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp_valid_i = 1'b1;
            disp_i = mk_op(30 + k, ALU_INST, 0, 0, 1'b1, 1'b1);
            tick();
        end
        disp_valid_i = 1'b0;
        chk_issue("t5_pre", 30);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t5_vld", 64'(exe_o.base.valid), 64'd0);
        chk("t5_rdy", 64'(disp_ready_o), 64'd1);
        exe_ready_i = 1'b1;
        tick();
        chk("t5_stale0", 64'(exe_o.base.valid), 64'd0);
        tick();
        chk("t5_stale1", 64'(exe_o.base.valid), 64'd0);
        disp_valid_i = 1'b1;
        disp_i = mk_op(40, ALU_INST, 0, 0, 1'b1, 1'b1);
        tick();
        disp_valid_i = 1'b0;
        tick();
        chk_issue("t5_new", 40);
        tick();
        tick();

        // 6: back-to-back stream across pointer wrap
        for (int c = 0; c < 12; c++) begin
            disp_valid_i = (c < 10);
            disp_i = mk_op(50 + c, BR_INST, 0, 0, 1'b1, 1'b1);
            chk($sformatf("t6_rdy%0d", c), 64'(disp_ready_o), 64'd1);
            if (c >= 2) begin
                chk_issue($sformatf("t6_c%0d", c), 50 + c - 2);
                chk($sformatf("t6_pc%0d", c), 64'(exe_o.pc), 64'((50 + c - 2) * 4));
            end
            tick();
        end
        disp_valid_i = 1'b0;
        chk("t6_end", 64'(exe_o.base.valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
